// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and constants for the R-format datapath front
//               end: fetch-stage state encoding, word width, default program
//               bounds and a PC alignment helper.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int WORD_W = 32;

    localparam logic [WORD_W-1:0] DEF_RESET_PC = 32'h0000_0000;
    localparam logic [WORD_W-1:0] DEF_END_PC   = 32'h0000_0080;

    // Fetch-stage sequencing states.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        DRAIN = 2'b10,
        HALT  = 2'b11
    } state_t;

    // Instruction addresses must sit on a 4-byte boundary.
    function automatic logic is_word_aligned(input logic [WORD_W-1:0] addr);
        return (addr[1:0] == 2'b00);
    endfunction

endpackage : cpu_pkg
`default_nettype wire

// File: rtl/if_stage_if.sv
`default_nettype none
// ============================================================================
// Module      : if_stage_if
// Description : Bundle of the fetch stage's non-clock signals.
//               master : the fetch stage itself.
//               slave  : core adder / instruction memory / downstream consumer.
// Ports       : start, pc_out, pc_next_in, instr_in      - core/program side
//               ifid_instr, ifid_pc, ifid_valid, ifid_ready - IF/ID handshake
//               halted, fault, fetch_count                 - status
// Revision    : 1.0 - initial release
// ============================================================================
interface if_stage_if
    import cpu_pkg::*;
#(
    parameter int CNT_W = 16
);
    logic              start;
    logic [WORD_W-1:0] pc_out;
    logic [WORD_W-1:0] pc_next_in;
    logic [WORD_W-1:0] instr_in;
    logic [WORD_W-1:0] ifid_instr;
    logic [WORD_W-1:0] ifid_pc;
    logic              ifid_valid;
    logic              ifid_ready;
    logic              halted;
    logic              fault;
    logic [CNT_W-1:0]  fetch_count;

    modport master (
        input  start, pc_next_in, instr_in, ifid_ready,
        output pc_out, ifid_instr, ifid_pc, ifid_valid, halted, fault, fetch_count
    );

    modport slave (
        output start, pc_next_in, instr_in, ifid_ready,
        input  pc_out, ifid_instr, ifid_pc, ifid_valid, halted, fault, fetch_count
    );

endinterface : if_stage_if
`default_nettype wire

// File: rtl/if_stage_ifid_reg.sv
`default_nettype none
// ============================================================================
// Module      : ifid_reg
// Description : One-entry IF/ID buffer with valid/ready output handshake.
//               A load always wins and overwrites the entry, which gives
//               bubble-free pass-through when the consumer takes the old entry
//               in the same cycle. Without a load, a completed handshake
//               empties the buffer.
// Ports       : clk, rst          - clock, synchronous active-high reset
//               load              - capture instr_in/pc_in this cycle
//               instr_in, pc_in   - entry to capture
//               ready             - consumer accepts the entry
//               instr_out, pc_out - buffered entry
//               valid             - buffer holds an entry
// Revision    : 1.0 - initial release
// ============================================================================
module ifid_reg
    import cpu_pkg::*;
(
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              load,
    input  wire logic [WORD_W-1:0] instr_in,
    input  wire logic [WORD_W-1:0] pc_in,
    input  wire logic              ready,
    output      logic [WORD_W-1:0] instr_out,
    output      logic [WORD_W-1:0] pc_out,
    output      logic              valid
);

    logic [WORD_W-1:0] r_instr;
    logic [WORD_W-1:0] r_pc;
    logic              r_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr <= '0;
            r_pc    <= '0;
            r_valid <= 1'b0;
        end else if (load) begin
            r_instr <= instr_in;
            r_pc    <= pc_in;
            r_valid <= 1'b1;
        end else if (r_valid && ready) begin
            r_valid <= 1'b0;
        end
    end

    assign instr_out = r_instr;
    assign pc_out    = r_pc;
    assign valid     = r_valid;

endmodule : ifid_reg
`default_nettype wire

// File: rtl/if_stage.sv
`default_nettype none
// ============================================================================
// Module      : if_stage
// Description : Instruction-fetch stage. Owns the PC, presents it to the
//               core, captures each instruction with its PC into a one-entry
//               IF/ID buffer, sequences start / end-of-program drain / halt
//               and counts captured instructions (saturating).
// Ports       : clk  - system clock, rising edge
//               rst  - synchronous active-high reset
//               bus  - if_stage_if.master (start, PC/instruction bus,
//                      IF/ID handshake, halted/fault/fetch_count status)
// Revision    : 1.0 - initial release
// ============================================================================
module if_stage
    import cpu_pkg::*;
#(
    parameter logic [WORD_W-1:0] RESET_PC = DEF_RESET_PC,
    parameter logic [WORD_W-1:0] END_PC   = DEF_END_PC,
    parameter int                CNT_W    = 16
)(
    input  wire logic   clk,
    input  wire logic   rst,
    if_stage_if.master  bus
);

    localparam logic [CNT_W-1:0] c_cnt_max = '1;

    state_t            r_state;
    logic [WORD_W-1:0] r_pc;
    logic [CNT_W-1:0]  r_count;
    logic              r_halted;
    logic              r_fault;

    logic              w_valid;
    logic              w_accept;
    logic              w_at_end;
    logic              w_fetch;
    logic              w_next_ok;

    // The buffer can take a new entry when it is empty or being emptied now.
    assign w_accept  = !w_valid || bus.ifid_ready;
    assign w_at_end  = (r_pc == END_PC);
    assign w_fetch   = (r_state == RUN) && w_accept && !w_at_end;
    assign w_next_ok = is_word_aligned(bus.pc_next_in);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= IDLE;
            r_pc     <= RESET_PC;
            r_count  <= '0;
            r_halted <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    r_pc <= RESET_PC;
                    if (bus.start) begin
                        r_state <= RUN;
                    end
                end

                RUN: begin
                    if (w_at_end) begin
                        r_state <= DRAIN;
                    end else if (w_fetch) begin
                        if (r_count != c_cnt_max) begin
                            r_count <= r_count + 1'b1;
                        end
                        // A misaligned successor is still captured for its
                        // own PC, but the PC is frozen and the stage stops.
                        if (w_next_ok) begin
                            r_pc <= bus.pc_next_in;
                        end else begin
                            r_fault  <= 1'b1;
                            r_halted <= 1'b1;
                            r_state  <= HALT;
                        end
                    end
                end

                DRAIN: begin
                    // No loads happen here, so an accepted handshake empties
                    // the buffer at this same edge.
                    if (w_accept) begin
                        r_halted <= 1'b1;
                        r_state  <= HALT;
                    end
                end

                HALT: begin
                    r_halted <= 1'b1;
                end

                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    ifid_reg u_ifid_reg (
        .clk       (clk),
        .rst       (rst),
        .load      (w_fetch),
        .instr_in  (bus.instr_in),
        .pc_in     (r_pc),
        .ready     (bus.ifid_ready),
        .instr_out (bus.ifid_instr),
        .pc_out    (bus.ifid_pc),
        .valid     (w_valid)
    );

    assign bus.ifid_valid  = w_valid;
    assign bus.pc_out      = r_pc;
    assign bus.halted      = r_halted;
    assign bus.fault       = r_fault;
    assign bus.fetch_count = r_count;

endmodule : if_stage
`default_nettype wire

// File: tb/tb_if_stage.sv
`default_nettype none
// ============================================================================
// Module      : tb_if_stage
// Description : Scoreboard bench for if_stage. dut_a fetches 0x0..0xC
//               (END_PC=0x10); dut_b has END_PC equal to RESET_PC.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_if_stage;
    import cpu_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic force_mis = 1'b0;
    logic b_seen_valid = 1'b0;

    int n_checks = 0;
    int n_fail   = 0;

    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    if_stage_if #(.CNT_W(16)) bus_a ();
    if_stage_if #(.CNT_W(16)) bus_b ();

    if_stage #(.RESET_PC(32'h0), .END_PC(32'h10), .CNT_W(16)) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (bus_a)
    );

    if_stage #(.RESET_PC(32'h0), .END_PC(32'h0), .CNT_W(16)) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (bus_b)
    );

    // Core adder and combinational instruction memory models.
    assign bus_a.instr_in   = 32'hA000_0000 | bus_a.pc_out;
    assign bus_a.pc_next_in = (force_mis && bus_a.pc_out == 32'h4) ? 32'h6 : bus_a.pc_out + 32'h4;
    assign bus_b.instr_in   = 32'hB000_0000 | bus_b.pc_out;
    assign bus_b.pc_next_in = bus_b.pc_out + 32'h4;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic wait_halted_a(input int max_cycles);
        int n = 0;
        while (!bus_a.halted && n < max_cycles) begin
            tick();
            n++;
        end
        check("halt_timeout", {31'd0, bus_a.halted}, 32'd1);
    endtask

    task automatic pulse_start_a();
        bus_a.start = 1'b1;
        tick();
        bus_a.start = 1'b0;
    endtask

    // Monitor: every completed IF/ID handshake must match the next expected PC.
    always @(negedge clk) begin
        if (!rst && bus_a.ifid_valid && bus_a.ifid_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_entry", bus_a.ifid_pc, 32'hFFFF_FFFF);
            end else begin
                logic [31:0] e;
                e = exp_q.pop_front();
                check("sb_pc", bus_a.ifid_pc, e);
                check("sb_instr", bus_a.ifid_instr, 32'hA000_0000 | e);
            end
        end
        if (bus_b.ifid_valid) begin
            b_seen_valid = 1'b1;
        end
    end

    initial begin
        bus_a.start = 1'b0;
        bus_a.ifid_ready = 1'b1;
        bus_b.start = 1'b0;
        bus_b.ifid_ready = 1'b1;
        tick();
        tick();

        // Reset state
        check("rst_pc", bus_a.pc_out, 32'h0);
        check("rst_valid", {31'd0, bus_a.ifid_valid}, 32'd0);
        check("rst_ifid_pc", bus_a.ifid_pc, 32'h0);
        check("rst_ifid_instr", bus_a.ifid_instr, 32'h0);
        check("rst_halted", {31'd0, bus_a.halted}, 32'd0);
        check("rst_fault", {31'd0, bus_a.fault}, 32'd0);
        check("rst_count", 32'(bus_a.fetch_count), 32'd0);
        rst = 1'b0;
        tick();

        // Straight run, ready held high
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        pulse_start_a();
        check("t1_no_capture_yet", {31'd0, bus_a.ifid_valid}, 32'd0);
        for (int i = 0; i < 4; i++) begin
            tick();
            check("t1_seq_pc", bus_a.ifid_pc, 32'(i * 4));
            check("t1_seq_valid", {31'd0, bus_a.ifid_valid}, 32'd1);
        end
        wait_halted_a(5);
        check("t1_count", 32'(bus_a.fetch_count), 32'd4);
        check("t1_pc", bus_a.pc_out, 32'h10);
        check("t1_fault", {31'd0, bus_a.fault}, 32'd0);
        check("t1_valid", {31'd0, bus_a.ifid_valid}, 32'd0);
        check("t1_q_empty", 32'(exp_q.size()), 32'd0);

        // Start after halt is ignored
        pulse_start_a();
        tick();
        check("t1_restart_pc", bus_a.pc_out, 32'h10);
        check("t1_restart_cnt", 32'(bus_a.fetch_count), 32'd4);
        check("t1_restart_state", 32'(dut_a.r_state), 32'(HALT));

        // Backpressure after the first capture
        do_reset();
        bus_a.ifid_ready = 1'b0;
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        pulse_start_a();
        tick();
        for (int i = 0; i < 3; i++) begin
            if (i == 1) bus_a.start = 1'b1;   // start during RUN is ignored
            tick();
            bus_a.start = 1'b0;
            check("t2_hold_ifid_pc", bus_a.ifid_pc, 32'h0);
            check("t2_hold_pc", bus_a.pc_out, 32'h4);
            check("t2_hold_cnt", 32'(bus_a.fetch_count), 32'd1);
        end
        bus_a.ifid_ready = 1'b1;
        wait_halted_a(10);
        check("t2_count", 32'(bus_a.fetch_count), 32'd4);
        check("t2_pc", bus_a.pc_out, 32'h10);
        check("t2_q_empty", 32'(exp_q.size()), 32'd0);

        // Misaligned next PC at 0x4
        do_reset();
        force_mis = 1'b1;
        exp_q = '{32'h0, 32'h4};
        pulse_start_a();
        wait_halted_a(6);
        check("t3_fault", {31'd0, bus_a.fault}, 32'd1);
        check("t3_pc", bus_a.pc_out, 32'h4);
        check("t3_count", 32'(bus_a.fetch_count), 32'd2);
        check("t3_held_pc", bus_a.ifid_pc, 32'h4);
        pulse_start_a();
        tick();
        check("t3_q_empty", 32'(exp_q.size()), 32'd0);
        check("t3_after_pc", bus_a.pc_out, 32'h4);
        check("t3_after_cnt", 32'(bus_a.fetch_count), 32'd2);
        check("t3_drained", {31'd0, bus_a.ifid_valid}, 32'd0);
        force_mis = 1'b0;

        // Reset mid-RUN with a valid entry
        do_reset();
        exp_q = '{32'h0};
        pulse_start_a();
        tick();
        tick();
        check("t4_pre_pc", bus_a.pc_out, 32'h8);
        check("t4_pre_valid", {31'd0, bus_a.ifid_valid}, 32'd1);
        rst = 1'b1;
        tick();
        check("t4_pc", bus_a.pc_out, 32'h0);
        check("t4_valid", {31'd0, bus_a.ifid_valid}, 32'd0);
        check("t4_count", 32'(bus_a.fetch_count), 32'd0);
        check("t4_state", 32'(dut_a.r_state), 32'(IDLE));
        rst = 1'b0;
        check("t4_q_empty", 32'(exp_q.size()), 32'd0);
        exp_q = '{32'h0, 32'h4, 32'h8, 32'hC};
        pulse_start_a();
        wait_halted_a(10);
        check("t4_again_count", 32'(bus_a.fetch_count), 32'd4);
        check("t4_again_q", 32'(exp_q.size()), 32'd0);

        // END_PC equal to RESET_PC
        do_reset();
        b_seen_valid = 1'b0;
        bus_b.start = 1'b1;
        tick();
        bus_b.start = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (!bus_b.halted) tick();
        end
        check("t5_halted", {31'd0, bus_b.halted}, 32'd1);
        check("t5_count", 32'(bus_b.fetch_count), 32'd0);
        check("t5_pc", bus_b.pc_out, 32'h0);
        tick();
        check("t5_never_valid", {31'd0, b_seen_valid}, 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_if_stage
`default_nettype wire

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage for the single-cycle R-format datapath. It owns the program counter and drives the PC address into the CPU core's fetch address input. It takes the incremented address back from the core's adder output and captures each fetched instruction with its PC into a one-entry IF/ID buffer. The buffer uses a valid/ready handshake toward the downstream consumer. The block also sequences start, end-of-program drain and halt, and counts retired fetches.

## Interface
- RESET_PC, 32'h0000_0000: PC value loaded on reset.
- END_PC, 32'h0000_0080: first byte address past the program; fetch stops when PC reaches it.
- CNT_W, 16: width of the fetch counter.

- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  one-cycle pulse; begins fetching; honoured only in IDLE.
- pc_out  out  32  current PC; drives the core's AddrIn.
- pc_next_in  in  32  incremented PC; driven by the core's AddrOut (pc_out+4).
- instr_in  in  32  instruction returned combinationally by instruction memory for pc_out.
- ifid_instr  out  32  buffered instruction.
- ifid_pc  out  32  PC of the buffered instruction.
- ifid_valid  out  1  buffer holds an instruction.
- ifid_ready  in  1  downstream accepts the buffer this cycle.
- halted  out  1  program finished or faulted; sticky until rst.
- fault  out  1  misaligned next-PC detected; sticky until rst.
- fetch_count  out  CNT_W  number of instructions captured into the buffer.

## Operation
- States: IDLE, RUN, DRAIN, HALT. Encoding 2 bits: 00, 01, 10, 11.
- IDLE: PC held at RESET_PC. No captures. On `start` the state moves to RUN.
- RUN: define `accept = !ifid_valid || ifid_ready` and `fetch = RUN && accept && (pc_out != END_PC)`.
  - When `fetch` is true, load ifid_instr/ifid_pc from instr_in/pc_out, set ifid_valid, set pc_out to pc_next_in, and increment fetch_count.
  - When ifid_valid && ifid_ready && !fetch, clear ifid_valid.
- RUN to DRAIN: when pc_out == END_PC. This covers END_PC == RESET_PC, which drains immediately with zero fetches.
- RUN to HALT with fault: when a fetch would load a pc_next_in whose bits [1:0] != 0. In that case the capture still happens but the PC does not update, and fault is set.
- DRAIN: no fetch. When ifid_valid is 0, or becomes 0 this cycle through the handshake, the state moves to HALT.
- HALT: halted=1. The buffer drains normally if a fault entry is still held. start is ignored.
- Comparison to END_PC is exact equality, so END_PC must be word-aligned. pc_out never wraps past END_PC.
- fetch_count saturates at all-ones; it does not wrap.
- start in RUN, DRAIN or HALT is ignored. No restart without rst.

## Timing
- All outputs are registered except none. pc_out, ifid_*, halted, fault and fetch_count are flops.
- Reset values: pc_out=RESET_PC, ifid_instr=0, ifid_pc=0, ifid_valid=0, halted=0, fault=0, fetch_count=0, state=IDLE.
- rst asserted mid-operation takes effect at the next edge. Any buffered instruction is discarded with no handshake.
- Latency: start at edge N gives RUN from N+1. The first capture is at edge N+2, after which ifid_valid=1 with ifid_pc=RESET_PC.
- Throughput: one instruction per cycle while ifid_ready=1.
- Backpressure: ifid_valid=1 and ifid_ready=0 holds the buffer, PC and count stable.
- A simultaneous ready and fetch in the same cycle replaces the entry (pass-through) with no bubble.
- instr_in is sampled in the same cycle that pc_out is presented; instruction memory is combinational.

## Structure
- Shared package `cpu_pkg`: state enum (IDLE/RUN/DRAIN/HALT), WORD_W=32, default RESET_PC/END_PC constants.
- One natural sub-module: `ifid_reg`, the one-entry valid/ready buffer holding instr+pc.
- The PC register, FSM and counter stay in if_stage.

## Test plan
- Reset, start, END_PC=0x10, ready=1: ifid_pc is 0x0, 0x4, 0x8, 0xC on consecutive cycles; DRAIN follows, then halted=1; fetch_count=4; pc_out=0x10.
- Backpressure: ready=0 for 3 cycles after the first capture leaves ifid_pc=0x0 and pc_out=0x4 unchanged. ready=1 then resumes at 0x4 with no loss or duplication.
- Misaligned next PC: force pc_next_in=0x6 at pc=0x4. The 0x4 entry is captured, fault=1, halted=1, pc_out stays 0x4, fetch_count=2.
- END_PC=RESET_PC: start leads to halted within 2 cycles, fetch_count=0, ifid_valid never 1.
- Reset mid-RUN at pc=0x8 with valid entry: next cycle pc_out=RESET_PC, ifid_valid=0, fetch_count=0, state IDLE. A second start works normally.
- start pulsed during RUN and after HALT: no effect on PC, count or state.
